// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the ball sequencer and its neighbours: frame tick
// source, platform position, brick hit, player keys, and the ball state
// that feeds the colour mapper.
interface ball_motion_ctrl_if;
    logic       frame_clk;
    logic [9:0] platX;
    logic [8:0] platY;
    logic       launch;
    logic       brick_hit;
    logic       restart;
    logic [9:0] ballX;
    logic [8:0] ballY;
    logic [1:0] lives;
    logic       serving;
    logic       game_over;
    logic       lost_pulse;

    // game side: drives the inputs, watches the ball
    modport master (
        output frame_clk, platX, platY, launch, brick_hit, restart,
        input  ballX, ballY, lives, serving, game_over, lost_pulse
    );

    // ball sequencer side
    modport slave (
        input  frame_clk, platX, platY, launch, brick_hit, restart,
        output ballX, ballY, lives, serving, game_over, lost_pulse
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Ball sprite sequencer. Advances the ball centre once per frame tick,
// handles serve/launch, wall, platform and brick reflections, ball loss,
// the lives count and game over.
module ball_motion_ctrl #(
    parameter int BALL_R      = 10,
    parameter int STEP        = 2,
    parameter int PLAT_HALF_W = 128,
    parameter int PLAT_HALF_H = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int LIVES_INIT  = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic               Clk,
    input  logic               Reset_n,
    ball_motion_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_SERVE, S_MOVE, S_LOST, S_OVER} state_t;

    localparam int CW = $clog2(LOST_FRAMES + 1);

    localparam logic signed [11:0] C_R    = 12'(BALL_R);
    localparam logic signed [11:0] C_XMAX = 12'(SCREEN_W - 1 - BALL_R);
    localparam logic signed [11:0] C_YBOT = 12'(SCREEN_H - 1);
    localparam logic signed [11:0] C_PHW  = 12'(PLAT_HALF_W);
    localparam logic signed [11:0] C_PHH  = 12'(PLAT_HALF_H);
    localparam logic signed [3:0]  C_STEP = 4'(STEP);
    localparam logic [CW-1:0]      C_LAST = CW'(LOST_FRAMES - 1);

    // [0],[1] synchronize, [2] holds the previous synced value for edge detect
    logic [2:0] r_fc_sync, r_la_sync, r_rs_sync;

    state_t            r_st, w_st_n;
    logic [9:0]        r_ballX, w_bx_n;
    logic [8:0]        r_ballY, w_by_n;
    logic signed [3:0] r_vx, w_vx_n;
    logic signed [3:0] r_vy, w_vy_n;
    logic [1:0]        r_lives, w_lives_n;
    logic [CW-1:0]     r_cnt, w_cnt_n;
    logic              r_hit, w_hit_n;
    logic              r_lp, w_lp_n;

    logic              w_tick, w_launch, w_restart, w_hit_now;
    logic signed [3:0] w_vy_eff;
    logic signed [11:0] w_vx12, w_vy12, w_cx, w_cy, w_px, w_py;
    logic [9:0]        w_sx;
    logic [8:0]        w_sy;
    logic              w_plat_hit;

    assign w_tick    = r_fc_sync[1] & ~r_fc_sync[2];
    assign w_launch  = r_la_sync[1] & ~r_la_sync[2];
    assign w_restart = r_rs_sync[1] & ~r_rs_sync[2];

    // a hit pulse landing on the tick cycle itself still reverses this frame
    assign w_hit_now = r_hit | bus.brick_hit;
    assign w_vy_eff  = w_hit_now ? -r_vy : r_vy;

    assign w_vx12 = {{8{r_vx[3]}}, r_vx};
    assign w_vy12 = {{8{w_vy_eff[3]}}, w_vy_eff};
    assign w_cx   = $signed({2'b00, r_ballX}) + w_vx12;
    assign w_cy   = $signed({3'b000, r_ballY}) + w_vy12;
    assign w_px   = $signed({2'b00, bus.platX});
    assign w_py   = $signed({3'b000, bus.platY});

    // resting spot on top of the platform, used for serve and bounce
    assign w_sx = (w_px < C_R)    ? 10'(BALL_R) :
                  (w_px > C_XMAX) ? 10'(SCREEN_W - 1 - BALL_R) : bus.platX;
    assign w_sy = bus.platY - 9'(PLAT_HALF_H + BALL_R);

    // only a descending ball whose bottom edge is inside the platform band bounces
    assign w_plat_hit = (w_vy_eff > 4'sd0)
                     && (w_cy + C_R >= w_py - C_PHH)
                     && (w_cy + C_R <= w_py + C_PHH)
                     && (w_cx + C_R >  w_px - C_PHW)
                     && (w_cx - C_R <  w_px + C_PHW);

    // input synchronizers and edge-detect history
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fc_sync <= '0;
            r_la_sync <= '0;
            r_rs_sync <= '0;
        end else begin
            r_fc_sync <= {r_fc_sync[1:0], bus.frame_clk};
            r_la_sync <= {r_la_sync[1:0], bus.launch};
            r_rs_sync <= {r_rs_sync[1:0], bus.restart};
        end
    end

    // state and ball registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_st    <= S_SERVE;
            r_ballX <= 10'(SCREEN_W / 2);
            r_ballY <= 9'(SCREEN_H / 2);
            r_vx    <= 4'sd0;
            r_vy    <= 4'sd0;
            r_lives <= 2'(LIVES_INIT);
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_lp    <= 1'b0;
        end else begin
            r_st    <= w_st_n;
            r_ballX <= w_bx_n;
            r_ballY <= w_by_n;
            r_vx    <= w_vx_n;
            r_vy    <= w_vy_n;
            r_lives <= w_lives_n;
            r_cnt   <= w_cnt_n;
            r_hit   <= w_hit_n;
            r_lp    <= w_lp_n;
        end
    end

    // next state, per-frame motion and reflections
    always_comb begin
        w_st_n    = r_st;
        w_bx_n    = r_ballX;
        w_by_n    = r_ballY;
        w_vx_n    = r_vx;
        w_vy_n    = r_vy;
        w_lives_n = r_lives;
        w_cnt_n   = r_cnt;
        w_hit_n   = 1'b0;
        w_lp_n    = 1'b0;
        unique case (r_st)
            S_SERVE: begin
                if (w_tick) begin
                    w_bx_n = w_sx;
                    w_by_n = w_sy;
                end
                if (w_launch) begin
                    w_vx_n = C_STEP;
                    w_vy_n = -C_STEP;
                    w_st_n = S_MOVE;
                end
            end
            S_MOVE: begin
                w_hit_n = w_hit_now;
                if (w_tick) begin
                    w_hit_n = 1'b0;
                    w_vy_n  = w_vy_eff;
                    if (w_cx <= C_R) begin
                        w_bx_n = 10'(BALL_R);
                        w_vx_n = C_STEP;
                    end else if (w_cx >= C_XMAX) begin
                        w_bx_n = 10'(SCREEN_W - 1 - BALL_R);
                        w_vx_n = -C_STEP;
                    end else begin
                        w_bx_n = w_cx[9:0];
                    end
                    if (w_cy <= C_R) begin
                        w_by_n = 9'(BALL_R);
                        w_vy_n = C_STEP;
                    end else if (w_plat_hit) begin
                        w_by_n = w_sy;
                        w_vy_n = -C_STEP;
                    end else if (w_cy + C_R >= C_YBOT) begin
                        w_by_n    = 9'(SCREEN_H - 1 - BALL_R);
                        w_vx_n    = 4'sd0;
                        w_vy_n    = 4'sd0;
                        w_lives_n = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                        w_lp_n    = 1'b1;
                        w_cnt_n   = '0;
                        w_st_n    = S_LOST;
                    end else begin
                        w_by_n = w_cy[8:0];
                    end
                end
            end
            S_LOST: begin
                if (w_tick) begin
                    if (r_cnt == C_LAST) begin
                        w_cnt_n = '0;
                        w_st_n  = (r_lives == 2'd0) ? S_OVER : S_SERVE;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end
            end
            S_OVER: begin
                if (w_restart) begin
                    w_lives_n = 2'(LIVES_INIT);
                    w_st_n    = S_SERVE;
                end
            end
            default: w_st_n = S_SERVE;
        endcase
    end

    assign bus.ballX      = r_ballX;
    assign bus.ballY      = r_ballY;
    assign bus.lives      = r_lives;
    assign bus.serving    = (r_st == S_SERVE);
    assign bus.game_over  = (r_st == S_OVER);
    assign bus.lost_pulse = r_lp;

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Frame-rate sequencer for the ball sprite in the breakout game. Each frame it owns and updates the ball-centre registers that feed the colour mapper's ball scope check.
- Handles serve, launch, wall, platform and brick reflections.
- Handles ball loss, lives and game over.
- Sits between the VGA controller (frame tick source), the platform controller (platX/platY), the brick module (hit pulse) and the colour mapper.

Parameters:
BALL_R, 10, ball radius in pixels (sprite is 20x20)
STEP, 2, per-frame speed magnitude on each axis, 1..7
PLAT_HALF_W, 128, platform half width in pixels
PLAT_HALF_H, 8, platform half height in pixels
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
LIVES_INIT, 3, lives after reset or restart, 1..3
LOST_FRAMES, 60, frames held in LOST before re-serve

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  VGA vertical sync, asynchronous to logic; a rising edge marks a frame
platX  in  10  platform centre X
platY  in  9  platform centre Y
launch  in  1  level from a key; its rising edge serves the ball
brick_hit  in  1  single-cycle pulse from brick logic when the ball overlaps a live brick
restart  in  1  level; its rising edge leaves GAMEOVER
ballX  out  10  ball centre X
ballY  out  9  ball centre Y
lives  out  2  remaining lives
serving  out  1  high in SERVE
game_over  out  1  high in GAMEOVER
lost_pulse  out  1  one-cycle pulse on entry to LOST

Behaviour:
Clock and reset:
- Single clock Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: ballX=320, ballY=240, vx=0, vy=0, lives=LIVES_INIT, state=SERVE, serving=1, game_over=0, lost_pulse=0.
- All input synchronizers and edge detectors are also cleared by reset.

Frame tick and input edges:
- frame_clk passes through a 2-flop synchronizer plus a rising-edge detector, giving a 1-cycle tick.
- Tick latency is 3 Clk cycles after the raw edge.
- launch and restart use the same synchronize-and-edge-detect structure.
- All position updates occur only on the tick cycle, as a single registered update.

Arithmetic:
- Velocity vx, vy are 4-bit signed values in {-STEP, 0, +STEP}.
- Per-tick math is 12-bit signed: cx = ballX + vx, cy = ballY + vy.

SERVE state:
- On each tick: ballX <= clamp(platX, BALL_R, SCREEN_W-1-BALL_R) and ballY <= platY - PLAT_HALF_H - BALL_R.
- On a launch edge: vx=+STEP, vy=-STEP, go to MOVE. Position updates begin at the next tick.

MOVE state, brick hit:
- A sticky hit flag is set by brick_hit on any cycle, including the tick cycle itself.
- On a tick with the flag set: vy is negated before cx/cy are formed, then the flag clears.
- Multiple hits within one frame count as one reversal.

MOVE state, X checks (applied to cx):
- cx <= BALL_R: ballX=BALL_R, vx=+STEP.
- cx >= SCREEN_W-1-BALL_R: ballX=SCREEN_W-1-BALL_R, vx=-STEP.
- Otherwise ballX=cx.

MOVE state, Y checks (applied to cy, first match wins):
1. Top: cy <= BALL_R: ballY=BALL_R, vy=+STEP.
2. Platform: all of vy>0, cy+BALL_R >= platY-PLAT_HALF_H, cy+BALL_R <= platY+PLAT_HALF_H, cx+BALL_R > platX-PLAT_HALF_W, cx-BALL_R < platX+PLAT_HALF_W. Result: ballY=platY-PLAT_HALF_H-BALL_R, vy=-STEP.
3. Bottom: cy+BALL_R >= SCREEN_H-1: ballY=SCREEN_H-1-BALL_R, vx=vy=0, lives decrements (saturating at 0), lost_pulse=1, go to LOST.
4. Otherwise ballY=cy.
- A corner hit (X and Y conditions together) reflects both axes in the same tick.

LOST state:
- Ball frozen. A frame counter counts ticks.
- After LOST_FRAMES ticks: if lives==0 go to GAMEOVER, else go to SERVE.

GAMEOVER state:
- Ball frozen, game_over=1. launch is ignored.
- On a restart edge: lives=LIVES_INIT, go to SERVE.

Other rules:
- A launch edge outside SERVE is ignored.
- A restart edge outside GAMEOVER is ignored.
- Reset asserted mid-frame or mid-LOST aborts immediately to the reset values.

Test Plan:
1. Reset release, platX=320, platY=460, 3 ticks -> ballX=320, ballY=442, serving=1, lives=3.
2. Serve tracking with platX=5 -> ballX clamps to 10. Then a launch edge -> state MOVE, and after one tick ballX=12, ballY=440.
3. Right wall: in MOVE with ballX=627, vx=+2, tick -> ballX=629, vx=-2. Next tick -> ballX=627.
4. Platform bounce: ballX=300, ballY=440, vy=+2, platX=320, platY=460, tick -> ballY=442, vy=-2. Same setup with platX=500 -> no bounce, ballY=442, vy=+2.
5. brick_hit pulse mid-frame with vy=-2 at ballY=200, tick -> ballY=202, vy=+2. Two pulses in one frame -> single reversal.
6. Miss with lives=1:
   - Tick -> lost_pulse for 1 cycle, lives=0.
   - 60 ticks later -> game_over=1; a launch edge then has no effect.
   - restart edge -> lives=3, serving=1.
